serial_subtractor_8: RTL and testbench
======================================

# serial_subtractor_8

Bit-serial 8-bit subtractor computing D = A − B − bin, LSB first, using one borrow flop and 8 shift cycles. It is the inverse-operation companion to the 8-bit ripple-carry adder in the arithmetic datapath. It trades the adder's single-cycle combinational path for a start/done handshake and minimal logic. Results are checked by feeding D + B + bin back through the adder.

## Interface
Parameters:
- None. Width is fixed at 8 bits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only when ready = 1.
- A  input  8  minuend, unsigned. Captured on an accepted start.
- B  input  8  subtrahend, unsigned. Captured on an accepted start.
- bin  input  1  borrow-in. Captured on an accepted start.
- ready  output  1  high in IDLE; the block can accept start.
- done  output  1  one-cycle pulse; D, bout and ovf are valid from this cycle onward.
- D  output  8  difference, (A − B − bin) mod 256.
- bout  output  1  borrow-out; 1 iff A < B + bin (unsigned).
- ovf  output  1  signed overflow. Present only with SUB_SIGNED_OVF_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ready = 1.
  - start = 1 at a rising edge loads A → ra, B → rb, bin → borrow flop; clears the 3-bit bit counter; moves to SHIFT.
- SHIFT: each edge processes one bit.
  - d = ra[0] ^ rb[0] ^ borrow
  - borrow' = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & borrow)
  - ra and rb shift right by 1; d shifts into the MSB of the internal result register.
  - The counter increments. The edge that processes bit 7 (counter = 7) moves to DONE.
- DONE:
  - D ← internal result register; bout ← borrow flop; done = 1 for exactly one cycle.
  - The next edge moves to IDLE.
- D, bout and ovf change only on DONE entry and hold until the next completion. Intermediate shift values are never visible on D.
- start is ignored while ready = 0 (SHIFT or DONE). It is not queued.
- A, B and bin may change freely after the accepting edge without affecting the operation in progress.

## Timing
- Reset values, asynchronous and taking effect immediately on rst = 1:
  - state = IDLE, ready = 1, done = 0, D = 0, bout = 0, ovf = 0, counter = 0, internal registers = 0.
- Latency: start accepted at edge N; bits processed at edges N+1 … N+8. done = 1 and new D valid in the cycle after edge N+8. ready = 1 again after edge N+9.
- Throughput: one operation per 10 cycles. start held high continuously yields back-to-back operations every 10 cycles.
- ready is low from edge N through the DONE cycle. ready and done are never high simultaneously.
- Reset mid-operation (SHIFT or DONE):
  - The operation is abandoned and no done pulse occurs.
  - Outputs return to reset values; the previous D is not retained.
- rst deasserting coincident with start: the start is not accepted at that edge.
- Wrap-around: all arithmetic is mod 256. The counter wraps 7 → 0 and is reloaded on every accept.

## Configuration
- SUB_SIGNED_OVF_EN defined:
  - The ovf port exists and a captured sign register is added.
  - ovf ← (A[7] ^ B[7]) & (A[7] ^ D[7]), using the captured A and B sign bits, updated on DONE entry.
  - Reset value 0.
- SUB_SIGNED_OVF_EN undefined:
  - The ovf port is absent and no sign logic is synthesised.
  - All other behaviour is identical.

## Test plan
- A = 120, B = 240, bin = 0, start pulse → done exactly 9 cycles after the accepting edge; D = 136, bout = 1.
- A = 200, B = 50, bin = 1 → D = 149, bout = 0. A = 0, B = 0, bin = 1 → D = 255, bout = 1. A = 53, B = 53, bin = 0 → D = 0, bout = 0.
- start pulsed again 3 cycles into an operation with different operands → ignored; D reflects the first operands only; one done pulse.
- rst asserted at bit 4 of A = 10, B = 3 → immediately ready = 1, D = 0, bout = 0, no done. A new start with A = 10, B = 3 → D = 7, bout = 0.
- start held high with A = 255, B = 1, bin = 0 → done pulses every 10 cycles; D = 254, bout = 0 each time; ready and done never high together.
- With SUB_SIGNED_OVF_EN:
  - A = 128, B = 1 → D = 127, ovf = 1.
  - A = 100, B = 156 → D = 200, bout = 1, ovf = 1.
  - A = 5, B = 3 → ovf = 0.

Source files
------------

// File: rtl/serial_subtractor_8_if.sv
// Request/response bundle for serial_subtractor_8.
// Optional feature macro: SUB_SIGNED_OVF_EN adds the ovf response signal.
interface serial_subtractor_8_if;

    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       bin;
    logic       ready;
    logic       done;
    logic [7:0] D;
    logic       bout;
`ifdef SUB_SIGNED_OVF_EN
    logic       ovf;
`endif

`ifdef SUB_SIGNED_OVF_EN
    // Requester side
    modport master (
        output start, A, B, bin,
        input  ready, done, D, bout, ovf
    );

    // Subtractor side
    modport slave (
        input  start, A, B, bin,
        output ready, done, D, bout, ovf
    );
`else
    // Requester side
    modport master (
        output start, A, B, bin,
        input  ready, done, D, bout
    );

    // Subtractor side
    modport slave (
        input  start, A, B, bin,
        output ready, done, D, bout
    );
`endif

endinterface

// File: rtl/serial_subtractor_8.sv
// Bit-serial 8-bit subtractor: D = A - B - bin, LSB first, one borrow flop.
// Optional feature macro: SUB_SIGNED_OVF_EN adds signed overflow output ovf.
module serial_subtractor_8 (
    input  logic                  clk,
    input  logic                  rst,
    serial_subtractor_8_if.slave  bus
);

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;

    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    // Holds the seven low result bits; the eighth is merged straight into D.
    logic [W-2:0]  res;
    logic          borrow;
    logic [CW-1:0] cnt;

    logic          accept_c;
    logic          last_c;
    logic          d_bit_c;
    logic          borrow_nxt_c;

    logic          ready_q;
    logic          done_q;
    logic [W-1:0]  d_q;
    logic          bout_q;

`ifdef SUB_SIGNED_OVF_EN
    logic          sa;
    logic          sb;
    logic          ovf_q;
`endif

    // One-bit full-subtractor slice and handshake decode
    always_comb begin
        d_bit_c      = ra[0] ^ rb[0] ^ borrow;
        borrow_nxt_c = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & borrow);
        accept_c     = (state == S_IDLE) && bus.start;
        last_c       = (state == S_SHIFT) && (cnt == CW'(W - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == CW'(W - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture and per-bit shift datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra     <= '0;
            rb     <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (accept_c) begin
            ra     <= bus.A;
            rb     <= bus.B;
            res    <= '0;
            borrow <= bus.bin;
            cnt    <= '0;
        end else if (state == S_SHIFT) begin
            ra     <= {1'b0, ra[W-1:1]};
            rb     <= {1'b0, rb[W-1:1]};
            res    <= {d_bit_c, res[W-2:1]};
            borrow <= borrow_nxt_c;
            cnt    <= cnt + CW'(1);
        end
    end

    // Handshake flags, registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            ready_q <= (state_nxt == S_IDLE);
            done_q  <= (state_nxt == S_DONE);
        end
    end

    // Result registers, written only on the edge that enters DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (last_c) begin
            d_q    <= {d_bit_c, res};
            bout_q <= borrow_nxt_c;
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    // Captured operand sign bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa <= 1'b0;
            sb <= 1'b0;
        end else if (accept_c) begin
            sa <= bus.A[W-1];
            sb <= bus.B[W-1];
        end
    end

    // Signed overflow: operand signs differ and result sign differs from A
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last_c) begin
            ovf_q <= (sa ^ sb) & (sa ^ d_bit_c);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.D     = d_q;
    assign bus.bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor_8.sv
// Directed self-checking bench for serial_subtractor_8 (SUB_SIGNED_OVF_EN optional).
module tb_serial_subtractor_8;

    logic clk;
    logic rst;

    int passed;
    int total;

    serial_subtractor_8_if bif ();

    serial_subtractor_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Wait for ready, present operands with start, return just after the accepting edge
    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int n;
        n = 0;
        @(negedge clk);
        while (bif.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(bif.ready), 32'd1);
        bif.A     = a;
        bif.B     = b;
        bif.bin   = bi;
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        bif.A     = ~a;
        bif.B     = b ^ 8'h5a;
        bif.bin   = ~bi;
    endtask

    // Edges after the accepting edge until done is seen; -1 on timeout
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bif.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic bi, input logic [7:0] exp_d, input logic exp_bout,
                         input logic exp_ovf);
        int lat;
        accept(a, b, bi);
        check({tag, "_ready_low"}, 32'(bif.ready), 32'd0);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_D"}, 32'(bif.D), 32'(exp_d));
        check({tag, "_bout"}, 32'(bif.bout), 32'(exp_bout));
`ifdef SUB_SIGNED_OVF_EN
        check({tag, "_ovf"}, 32'(bif.ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) check({tag, "_ovf_arg"}, 32'd0, 32'd1);
`endif
        @(posedge clk);
        #1;
        check({tag, "_ready_back"}, 32'(bif.ready), 32'd1);
        check({tag, "_done_pulse"}, 32'(bif.done), 32'd0);
        check({tag, "_D_hold"}, 32'(bif.D), 32'(exp_d));
    endtask

    initial begin
        int dones;
        int lat;
        int overlap;
        int done_cyc[$];
        logic d_ok;

        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        bif.start = 1'b0;
        bif.A     = '0;
        bif.B     = '0;
        bif.bin   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bif.ready), 32'd1);
        check("rst_done",  32'(bif.done),  32'd0);
        check("rst_D",     32'(bif.D),     32'd0);
        check("rst_bout",  32'(bif.bout),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("t120_240", 8'd120, 8'd240, 1'b0, 8'd136, 1'b1, 1'b0);
        do_op("t200_50b", 8'd200, 8'd50,  1'b1, 8'd149, 1'b0, 1'b0);
        do_op("t0_0b",    8'd0,   8'd0,   1'b1, 8'd255, 1'b1, 1'b0);
        do_op("t53_53",   8'd53,  8'd53,  1'b0, 8'd0,   1'b0, 1'b0);

        // Second start three cycles into an operation must be ignored
        accept(8'd20, 8'd7, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bif.A     = 8'd100;
        bif.B     = 8'd1;
        bif.bin   = 1'b0;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        dones = 0;
        d_ok  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (bif.done === 1'b1) begin
                dones++;
                if (bif.D !== 8'd13) d_ok = 1'b0;
            end
        end
        check("ignore_done_count", 32'(dones), 32'd1);
        check("ignore_D_ok", 32'(d_ok), 32'd1);
        check("ignore_D", 32'(bif.D), 32'd13);

        // Reset while bit 4 is pending
        accept(8'd10, 8'd3, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(bif.ready), 32'd1);
        check("midrst_D",     32'(bif.D),     32'd0);
        check("midrst_bout",  32'(bif.bout),  32'd0);
        check("midrst_done",  32'(bif.done),  32'd0);
        dones = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bif.done === 1'b1) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        do_op("t10_3", 8'd10, 8'd3, 1'b0, 8'd7, 1'b0, 1'b0);

        // start held high: back-to-back operations
        @(negedge clk);
        bif.A     = 8'd255;
        bif.B     = 8'd1;
        bif.bin   = 1'b0;
        bif.start = 1'b1;
        overlap = 0;
        d_ok    = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (bif.ready === 1'b1 && bif.done === 1'b1) overlap++;
            if (bif.done === 1'b1) begin
                done_cyc.push_back(i);
                if (bif.D !== 8'd254 || bif.bout !== 1'b0) d_ok = 1'b0;
            end
        end
        @(negedge clk);
        bif.start = 1'b0;
        check("b2b_done_count", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() >= 3) begin
            check("b2b_period1", 32'(done_cyc[1] - done_cyc[0]), 32'd10);
            check("b2b_period2", 32'(done_cyc[2] - done_cyc[1]), 32'd10);
        end
        check("b2b_results", 32'(d_ok), 32'd1);
        check("b2b_no_overlap", 32'(overlap), 32'd0);
        wait_done(lat);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_idle_ready", 32'(bif.ready), 32'd1);

`ifdef SUB_SIGNED_OVF_EN
        do_op("ovf_128_1",   8'd128, 8'd1,   1'b0, 8'd127, 1'b0, 1'b1);
        do_op("ovf_100_156", 8'd100, 8'd156, 1'b0, 8'd200, 1'b1, 1'b1);
        do_op("ovf_5_3",     8'd5,   8'd3,   1'b0, 8'd2,   1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
